// File: rtl/trap_ctrl_if.sv
// Bus bundle between the pipeline/CSR file and trap_ctrl, together with the
// exception-status and CSR address encodings both sides share.
`ifndef EXC_STATUS_WIDTH
`define EXC_STATUS_WIDTH 3
`endif
`ifndef EXC_STATUS_ECALL
`define EXC_STATUS_ECALL 3'd1
`endif
`ifndef EXC_STATUS_EBREAK
`define EXC_STATUS_EBREAK 3'd2
`endif
`ifndef EXC_STATUS_ILLEGAL
`define EXC_STATUS_ILLEGAL 3'd3
`endif
`ifndef EXC_STATUS_MRET
`define EXC_STATUS_MRET 3'd4
`endif
`ifndef CSR_MSTATUS
`define CSR_MSTATUS 12'h300
`endif
`ifndef CSR_MEPC
`define CSR_MEPC 12'h341
`endif
`ifndef CSR_MCAUSE
`define CSR_MCAUSE 12'h342
`endif

interface trap_ctrl_if #(
  parameter int NUM_IRQ = 4
);
  logic [`EXC_STATUS_WIDTH-1:0] exc_status;
  logic [31:0]                  inst_addr_i;
  logic                         br_taken;
  logic [31:0]                  br_target;
  logic [NUM_IRQ-1:0]           irq_i;
  logic [NUM_IRQ-1:0]           irq_en_i;
  logic                         global_interrupt_enable;
  logic [31:0]                  csr_mtvec;
  logic [31:0]                  csr_mepc;
  logic [31:0]                  csr_mstatus;
  logic                         hold_flag;
  logic [NUM_IRQ-1:0]           irq_pending_o;
  logic [NUM_IRQ-1:0]           irq_ack_o;
  logic                         csr_we;
  logic [11:0]                  csr_waddr;
  logic [31:0]                  csr_wdata;
  logic                         int_assert;
  logic [31:0]                  int_addr;

  modport master (
    output exc_status, inst_addr_i, br_taken, br_target, irq_i, irq_en_i,
           global_interrupt_enable, csr_mtvec, csr_mepc, csr_mstatus,
    input  hold_flag, irq_pending_o, irq_ack_o, csr_we, csr_waddr, csr_wdata,
           int_assert, int_addr
  );

  modport slave (
    input  exc_status, inst_addr_i, br_taken, br_target, irq_i, irq_en_i,
           global_interrupt_enable, csr_mtvec, csr_mepc, csr_mstatus,
    output hold_flag, irq_pending_o, irq_ack_o, csr_we, csr_waddr, csr_wdata,
           int_assert, int_addr
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: latches/prioritises interrupts, sequences the
// mepc/mstatus/mcause writes and redirects the pipeline to the handler or mepc.
module trap_ctrl #(
  parameter int                 NUM_IRQ        = 4,
  parameter logic [NUM_IRQ-1:0] IRQ_EDGE       = {NUM_IRQ{1'b0}},
  parameter int                 IRQ_CAUSE_BASE = 16
) (
  input logic       clk,
  input logic       rst_n,
  trap_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, MEPC, MSTATUS, MCAUSE, MRET, JUMP} state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] irq_prev_q, irq_pend_q, irq_pend_d;
  logic [NUM_IRQ-1:0] pending, eligible, irq_onehot, ack;
  logic [31:0]        cause_q, cause_d, pc_q, pc_d;
  logic               is_irq_q, is_irq_d, is_mret_q, is_mret_d;
  logic               csr_we_q, csr_we_d, int_assert_q, int_assert_d;
  logic [11:0]        csr_waddr_q, csr_waddr_d;
  logic [31:0]        csr_wdata_q, csr_wdata_d, int_addr_q, int_addr_d;
  logic               exc_req, mret_req, irq_found;
  logic [4:0]         irq_sel;
  logic [31:0]        exc_cause, trap_base;

  assign pending  = (irq_pend_q & IRQ_EDGE) | (bus.irq_i & ~IRQ_EDGE);
  assign eligible = pending & bus.irq_en_i & {NUM_IRQ{bus.global_interrupt_enable}};

  // Scan downwards so the lowest eligible index is the one left selected.
  always_comb begin
    irq_found  = 1'b0;
    irq_sel    = '0;
    irq_onehot = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        irq_found     = 1'b1;
        irq_sel       = 5'(i);
        irq_onehot    = '0;
        irq_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    exc_req   = 1'b1;
    exc_cause = '0;
    case (bus.exc_status)
      `EXC_STATUS_ECALL:   exc_cause = 32'd11;
      `EXC_STATUS_EBREAK:  exc_cause = 32'd3;
      `EXC_STATUS_ILLEGAL: exc_cause = 32'd2;
      default:             exc_req   = 1'b0;
    endcase
  end

  assign mret_req = (bus.exc_status == `EXC_STATUS_MRET);

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    pc_d      = pc_q;
    is_irq_d  = is_irq_q;
    is_mret_d = is_mret_q;
    ack       = '0;
    case (state_q)
      IDLE: begin
        if (exc_req) begin
          state_d   = MEPC;
          cause_d   = exc_cause;
          pc_d      = bus.br_taken ? (bus.br_target - 32'd4) : bus.inst_addr_i;
          is_irq_d  = 1'b0;
          is_mret_d = 1'b0;
        end else if (irq_found) begin
          state_d   = MEPC;
          cause_d   = {1'b1, 31'(IRQ_CAUSE_BASE) + 31'(irq_sel)};
          pc_d      = bus.br_taken ? bus.br_target : bus.inst_addr_i;
          is_irq_d  = 1'b1;
          is_mret_d = 1'b0;
          ack       = irq_onehot;
        end else if (mret_req) begin
          state_d   = MRET;
          is_irq_d  = 1'b0;
          is_mret_d = 1'b1;
        end
      end
      MEPC:    state_d = MSTATUS;
      MSTATUS: state_d = MCAUSE;
      MCAUSE:  state_d = JUMP;
      MRET:    state_d = JUMP;
      JUMP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Set beats clear: a fresh edge on the line being acked keeps it pending.
  assign irq_pend_d = ((irq_pend_q & ~ack) | (bus.irq_i & ~irq_prev_q)) & IRQ_EDGE;

  // Outputs are registered from the state being entered so they line up with it.
  always_comb begin
    trap_base    = {bus.csr_mtvec[31:2], 2'b00};
    csr_we_d     = 1'b0;
    csr_waddr_d  = '0;
    csr_wdata_d  = '0;
    int_assert_d = 1'b0;
    int_addr_d   = '0;
    case (state_d)
      MEPC: begin
        csr_we_d    = 1'b1;
        csr_waddr_d = `CSR_MEPC;
        csr_wdata_d = pc_d;
      end
      MSTATUS: begin
        csr_we_d           = 1'b1;
        csr_waddr_d        = `CSR_MSTATUS;
        csr_wdata_d        = bus.csr_mstatus;
        csr_wdata_d[7]     = bus.csr_mstatus[3];
        csr_wdata_d[3]     = 1'b0;
        csr_wdata_d[12:11] = 2'b11;
      end
      MCAUSE: begin
        csr_we_d    = 1'b1;
        csr_waddr_d = `CSR_MCAUSE;
        csr_wdata_d = cause_d;
      end
      MRET: begin
        csr_we_d       = 1'b1;
        csr_waddr_d    = `CSR_MSTATUS;
        csr_wdata_d    = bus.csr_mstatus;
        csr_wdata_d[3] = bus.csr_mstatus[7];
        csr_wdata_d[7] = 1'b1;
      end
      JUMP: begin
        int_assert_d = 1'b1;
        if (is_mret_d)
          int_addr_d = bus.csr_mepc;
        else if (bus.csr_mtvec[1:0] == 2'b01 && is_irq_d)
          int_addr_d = trap_base + {cause_d[29:0], 2'b00};
        else
          int_addr_d = trap_base;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      irq_prev_q <= '0;
      irq_pend_q <= '0;
      cause_q    <= '0;
      pc_q       <= '0;
      is_irq_q   <= 1'b0;
      is_mret_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= bus.irq_i;
      irq_pend_q <= irq_pend_d;
      cause_q    <= cause_d;
      pc_q       <= pc_d;
      is_irq_q   <= is_irq_d;
      is_mret_q  <= is_mret_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_we_q     <= 1'b0;
      csr_waddr_q  <= '0;
      csr_wdata_q  <= '0;
      int_assert_q <= 1'b0;
      int_addr_q   <= '0;
    end else begin
      csr_we_q     <= csr_we_d;
      csr_waddr_q  <= csr_waddr_d;
      csr_wdata_q  <= csr_wdata_d;
      int_assert_q <= int_assert_d;
      int_addr_q   <= int_addr_d;
    end
  end

  assign bus.hold_flag     = (state_q != IDLE) | exc_req | irq_found | mret_req;
  assign bus.irq_pending_o = pending;
  assign bus.irq_ack_o     = ack;
  assign bus.csr_we        = csr_we_q;
  assign bus.csr_waddr     = csr_waddr_q;
  assign bus.csr_wdata     = csr_wdata_q;
  assign bus.int_assert    = int_assert_q;
  assign bus.int_addr      = int_addr_q;

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Parametrised machine-mode trap controller, the successor to the single-source interrupt controller. It accepts synchronous exceptions from id_stage and NUM_IRQ external interrupt lines with per-line edge/level mode and per-line enable. It sequences the mepc/mstatus/mcause CSR writes, and redirects ex_stage to the trap vector (direct or vectored mode) or back to mepc on MRET. The pipeline is stalled via hold_flag for the whole sequence.

## Interface
- NUM_IRQ, 4: number of external interrupt lines (1..16).
- IRQ_EDGE, {NUM_IRQ{1'b0}}: per-line mode mask; 1 = rising-edge latched, 0 = level.
- IRQ_CAUSE_BASE, 16: cause code of line 0; line i uses IRQ_CAUSE_BASE+i.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- exc_status  in  `EXC_STATUS_WIDTH  id_stage status; uses `EXC_STATUS_ECALL/EBREAK/ILLEGAL/MRET, any other value = none.
- inst_addr_i  in  32  address of the instruction in id_stage.
- br_taken, br_target  in  1, 32  ex_stage branch resolution.
- irq_i  in  NUM_IRQ  raw interrupt lines (synchronous to clk).
- irq_en_i  in  NUM_IRQ  per-line enable (mie bits).
- global_interrupt_enable  in  1  mstatus.MIE.
- csr_mtvec, csr_mepc, csr_mstatus  in  32 each  current CSR values.
- hold_flag  out  1  stall request to the pipeline.
- irq_pending_o  out  NUM_IRQ  mip view: edge latches OR level lines.
- irq_ack_o  out  NUM_IRQ  one-hot, 1-cycle acknowledge of the taken line.
- csr_we, csr_waddr[11:0], csr_wdata[31:0]  out  CSR write port.
- int_assert  out  1  1-cycle redirect strobe.
- int_addr  out  32  redirect target.

## Operation
- Pending: edge line i sets pend[i] on irq_i rising edge (previous-sample register); cleared when the line is acknowledged. If set and clear occur in the same cycle, set wins. Level line pending = irq_i[i].
- Eligible irq: pending & irq_en_i, gated by global_interrupt_enable; lowest index wins.
- FSM states: IDLE, MEPC, MSTATUS, MCAUSE, MRET, JUMP.
- IDLE priority:
  - ECALL/EBREAK/ILLEGAL → MEPC. Cause 11/3/2, MSB 0. Saved PC = br_taken ? br_target-4 : inst_addr_i.
  - Else eligible irq → MEPC. Cause {1, IRQ_CAUSE_BASE+i}. Saved PC = br_taken ? br_target : inst_addr_i. irq_ack_o[i]=1 that cycle.
  - Else MRET → MRET.
- MEPC → MSTATUS → MCAUSE → JUMP → IDLE. MRET → JUMP → IDLE.
- CSR writes (registered, csr_we=1 only in these states):
  - MEPC: waddr=`CSR_MEPC, wdata = saved PC.
  - MSTATUS: MPIE←MIE, MIE←0, MPP[12:11]←2'b11, other bits kept.
  - MCAUSE: wdata = cause.
  - MRET: waddr=`CSR_MSTATUS; MIE←MPIE, MPIE←1, other bits kept.
- JUMP: int_assert=1.
  - After an MRET request: int_addr = csr_mepc.
  - After a trap: base = {csr_mtvec[31:2],2'b00}. If csr_mtvec[1:0]==2'b01 and the trap is an interrupt, int_addr = base + 4*cause[30:0]. Otherwise int_addr = base. Arithmetic is 32-bit wrap.
- Outside JUMP: int_assert=0, int_addr=0. When csr_we=0, waddr=0 and wdata=0.
- hold_flag = (state != IDLE) | (IDLE and any request that will be taken). Combinational.

## Timing
- Reset (async, any state): state=IDLE, edge latches and previous samples = 0, cause/saved PC = 0. Outputs csr_we=0, csr_waddr=0, csr_wdata=0, int_assert=0, int_addr=0, irq_ack_o=0. hold_flag=0 once inputs are idle.
- Trap accepted in cycle T: MEPC write visible T+1, MSTATUS T+2, MCAUSE T+3, int_assert T+4, IDLE at T+5. hold_flag is high T..T+4.
- MRET accepted in cycle T: mstatus write T+1, int_assert with csr_mepc T+2.
- Inputs (exc_status, irq_i) are ignored for FSM decisions outside IDLE. Edges arriving then are still latched and taken later.
- Exception and irq in the same IDLE cycle: exception taken, irq not acked and stays pending.
- Level line deasserted before being taken: no trap, no ack.

## Test plan
- ECALL with inst_addr_i=0x100, mtvec=0x200, mstatus=0x8 → writes mepc=0x100, mstatus=0x1880, mcause=0x0000000B; int_assert with int_addr=0x200 at T+4.
- Edge irq line 2 pulsed one cycle, enabled, MIE=1, mtvec=0x201, br_taken with br_target=0x340 → ack[2] at T, mepc=0x340, mcause=0x80000012, int_addr=0x248, pend[2] cleared.
- Lines 1 and 3 both level-high and enabled → line 1 taken first. After return, with line 1 dropped, line 3 is taken with mcause 0x80000013.
- EBREAK and enabled irq 0 in the same cycle → mcause=3. irq 0 remains in irq_pending_o and is taken after the sequence.
- MRET with mstatus=0x80, mepc=0x104 → mstatus write 0x88 at T+1, int_addr=0x104 at T+2.
- rst_n low at T+2 of a trap → state and all outputs are 0 immediately (asynchronously). No mcause write follows; latched edges are cleared.
